// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline widths, NOP encoding and fetch pair type
//
// Purpose: definitions shared by fetch, the fetch queue and decode.
//   XLEN         : datapath width (32)
//   NOP          : canonical RV32I no-op, addi x0,x0,0
//   fetch_pair_t : one fetched (PC, instruction) pair
package pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pair_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// rtl/fetch_queue_ram.sv - DEPTH x 64-bit storage for the fetch queue
//
// Purpose: entry storage with one synchronous write port and one
// asynchronous read port. Not reset: contents are only meaningful
// where the owning queue's pointers say so.
// Ports:
//   clk_i   : clock, write on rising edge
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : pair to write
//   raddr_i : read address
//   rdata_o : pair stored at raddr_i (combinational)
module fetch_queue_ram
    import pipeline_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  fetch_pair_t   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output fetch_pair_t   rdata_o
);

    fetch_pair_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - IF/ID decoupling queue with branch flush
//
// Purpose: buffers up to DEPTH (PC, instruction) pairs between fetch and
// decode, presents the oldest pair show-ahead, and drops everything on a
// taken branch/jump so decode never sees wrong-path instructions.
// Ports:
//   clk            : clock
//   reset          : asynchronous active-low reset
//   in_valid       : fetch presents a pair
//   PC_IF          : PC of fetched instruction
//   INSTRUCTION_IF : fetched instruction word
//   in_ready       : push accepted this cycle (drives fetch PC_write)
//   flush          : taken branch/jump, discards queue contents
//   out_valid      : head entry valid
//   out_ready      : decode consumes head (low = decode stall)
//   PC_ID          : head PC, 0 when empty
//   INSTRUCTION_ID : head instruction, NOP when empty
//   count          : occupancy 0..DEPTH
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [XLEN-1:0]  PC_IF,
    input  logic [XLEN-1:0]  INSTRUCTION_IF,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  PC_ID,
    output logic [XLEN-1:0]  INSTRUCTION_ID,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    logic        push;
    logic        pop;
    fetch_pair_t wr_pair;
    fetch_pair_t head_pair;

    // Handshake flags come from registered occupancy only, so there is no
    // combinational path from in_valid/out_ready/flush to any output.
    // A full queue refuses a push even when a pop happens in that cycle.
    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != '0);

    assign push = in_valid  && in_ready  && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign wr_pair.pc    = PC_IF;
    assign wr_pair.instr = INSTRUCTION_IF;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is plain overflow.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fetch_queue_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_pair),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_pair)
    );

    // Storage is never cleared, so mask the head when empty to keep stale
    // (possibly wrong-path) entries away from decode.
    assign PC_ID          = out_valid ? head_pair.pc    : '0;
    assign INSTRUCTION_ID = out_valid ? head_pair.instr : NOP;
    assign count          = count_q;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling buffer between the instruction-fetch stage and the decode stage of the 5-stage pipeline. It captures (PC, instruction) pairs produced by fetch each cycle, holds up to DEPTH of them while decode is stalled, and presents the oldest pair to decode in order. On a taken branch or jump it discards every queued entry so decode never sees wrong-path instructions. It replaces the plain IF/ID register and takes over the stall path: its `in_ready` drives fetch's `PC_write`.

## Interface
- `DEPTH`, 4: number of entries; power of two, minimum 2.
- `PTR_W`, $clog2(DEPTH): pointer width; derived, not overridden.
- `clk` input 1: single clock, all state on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: fetch presents a valid pair this cycle.
- `PC_IF` input 32: PC of the fetched instruction.
- `INSTRUCTION_IF` input 32: fetched instruction word.
- `in_ready` output 1: queue accepts a push this cycle; drives fetch `PC_write`.
- `flush` input 1: taken branch/jump (fetch `PCSrc`); discards queue contents.
- `out_valid` output 1: head entry is valid.
- `out_ready` input 1: decode consumes the head this cycle (low = decode stall).
- `PC_ID` output 32: PC of the head entry.
- `INSTRUCTION_ID` output 32: instruction of the head entry.
- `count` output PTR_W+1: number of occupied entries, 0..DEPTH.

## Operation
- Circular buffer with write pointer `wr_ptr`, read pointer `rd_ptr` and occupancy counter `count`. Pointers wrap from DEPTH-1 to 0.
- Push occurs when `in_valid && in_ready && !flush`. A push writes the pair at `wr_ptr`, then increments `wr_ptr`.
- Pop occurs when `out_valid && out_ready && !flush`. A pop increments `rd_ptr`.
- Counter update:
  - +1 for a push alone.
  - −1 for a pop alone.
  - Unchanged when a push and a pop happen in the same cycle.
- `in_ready = (count != DEPTH)`. When the queue is full, no push is accepted, even if a pop happens in the same cycle. There is no full-pass-through path.
- `out_valid = (count != 0)`. The head is read combinationally from the entry at `rd_ptr` (show-ahead).
- When empty, `PC_ID` = 32'h0 and `INSTRUCTION_ID` = `NOP` (32'h00000013, addi x0,x0,0). Stale storage is never exposed.
- `flush` has priority over everything. On the edge where `flush` is high:
  - `wr_ptr`, `rd_ptr` and `count` clear to 0.
  - A simultaneous push is dropped.
  - A simultaneous pop is ignored.
- Storage contents are not cleared by reset or flush; only the pointers and counter are.
- No FSM; state is `wr_ptr`, `rd_ptr`, `count` and the storage array.

## Timing
- Reset values while `reset` = 0 (asynchronous):
  - `wr_ptr`, `rd_ptr`, `count` = 0.
  - `out_valid` = 0, `in_ready` = 1.
  - `PC_ID` = 0, `INSTRUCTION_ID` = `NOP`.
- A reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency: a pair pushed at edge N appears on `PC_ID`/`INSTRUCTION_ID` with `out_valid` = 1 after edge N, provided the queue was empty. There is no same-cycle bypass.
- Sustained throughput is one push and one pop per cycle while 0 < `count` < DEPTH.
- `in_ready` and `out_valid` depend only on registered state. No combinational path exists from `in_valid`, `out_ready` or `flush` to any output.
- After a flush edge:
  - `out_valid` = 0 and `in_ready` = 1 in the next cycle.
  - The first post-branch fetch can be pushed in that same cycle.
- Upstream and downstream must hold `PC_IF`/`INSTRUCTION_IF` stable whenever `in_valid && !in_ready`. The queue does not register them until a push.

## Structure
- Shared package `pipeline_pkg` holds:
  - `XLEN` = 32.
  - `NOP` = 32'h00000013.
  - Typedef `fetch_pair_t` (32-bit PC and 32-bit instruction), also to be used by the decode stage.
- One sub-module is natural: `fetch_queue_ram`, a DEPTH × 64-bit array with one synchronous write port and one asynchronous read port, and no reset. The pointer and counter logic stays in `fetch_queue`.

## Test plan
- Reset, then push PCs 0x0, 0x4, 0x8 with `out_ready` = 0 → `count` = 3, `PC_ID` = 0x0, `in_ready` = 1. Then set `out_ready` = 1 → `PC_ID` reads 0x0, 0x4, 0x8 on consecutive cycles, after which `out_valid` = 0 and `INSTRUCTION_ID` = 32'h00000013.
- Fill to DEPTH = 4 (PCs 0x10..0x1C) with `in_valid` held high → `in_ready` = 0 and `count` = 4. A fifth pair held at 0x20 is accepted only on the cycle after the first pop.
- Simultaneous push and pop at `count` = 2 for 10 cycles → `count` stays 2, PCs emerge in order, and `wr_ptr`/`rd_ptr` wrap past 3 correctly.
- Start with 3 entries, then assert `flush` together with a push (PC 0x100) and `out_ready` = 1 → the next cycle shows `count` = 0, `out_valid` = 0, `in_ready` = 1. A subsequent push of 0x200 is the first PC seen on `PC_ID`.
- Drive `reset` low asynchronously between clock edges with `count` = 2 → `out_valid` drops before the next edge, and all outputs match their reset values.
- Empty queue, push 0x40 at edge N with `out_ready` = 1 → `out_valid` stays 0 during cycle N−1 (no bypass), is 1 after edge N, and the pop completes at edge N+1.
